// File: rtl/if_pc_predictor.sv
// Fetch front end: PC register, ROM drive and a 2-bit counter BHT
// that steers fetch to predicted-taken conditional branch targets.
module if_pc_predictor #(
  parameter int          BHT_IDX_W = 6,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_isTaken,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  logic [31:0]          pc_q, pc_d;
  logic                 ce_q, ce_d;
  logic [1:0]           bht_q [BHT_N];
  logic [1:0]           bht_d [BHT_N];
  logic [BHT_IDX_W-1:0] rd_idx;
  logic [BHT_IDX_W-1:0] upd_idx;
  logic [5:0]           opcode;
  logic                 is_branch;
  logic [31:0]          br_off;
  logic [31:0]          target;
  logic                 unused_ok;

  assign rom_ce   = ce_q;
  assign rom_addr = pc_q;
  assign if_pc    = ce_q ? pc_q : 32'h0;
  assign if_inst  = ce_q ? rom_data : 32'h0;

  // beq/bne/blez/bgtz share opcode prefix 0001
  assign opcode     = if_inst[31:26];
  assign is_branch  = (opcode[5:2] == 4'b0001);
  assign br_off     = {{14{if_inst[15]}}, if_inst[15:0], 2'b00};
  assign target     = pc_q + 32'd4 + br_off;
  assign rd_idx     = pc_q[BHT_IDX_W+1:2];
  assign upd_idx    = upd_pc[BHT_IDX_W+1:2];
  assign if_isTaken = is_branch & bht_q[rd_idx][1];

  assign unused_ok = ^{stall[5:1], upd_pc[31:BHT_IDX_W+2],
                       upd_pc[1:0]};

  always_comb begin
    pc_d = pc_q;
    ce_d = 1'b1;
    if (ce_q) begin
      if (redirect_valid)  pc_d = redirect_pc;
      else if (stall[0])   pc_d = pc_q;
      else if (if_isTaken) pc_d = target;
      else                 pc_d = pc_q + 32'd4;
    end
  end

  always_comb begin
    for (int i = 0; i < BHT_N; i++) bht_d[i] = bht_q[i];
    if (upd_valid) begin
      if (upd_taken) begin
        if (bht_q[upd_idx] != 2'b11)
          bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
      end else begin
        if (bht_q[upd_idx] != 2'b00)
          bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      ce_q <= 1'b0;
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else begin
      pc_q <= pc_d;
      ce_q <= ce_d;
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= bht_d[i];
    end
  end

endmodule

// File: tb/tb_if_pc_predictor.sv
// Bench for if_pc_predictor: directed scenarios then random traffic,
// checked against a behavioural fetch/BHT reference model.
module tb_if_pc_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_isTaken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;

  logic [31:0] mem [256];
  assign rom_data = mem[rom_addr[9:2]];

  always #5 clk = ~clk;

  if_pc_predictor #(.BHT_IDX_W(6), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data),
    .if_pc(if_pc), .if_inst(if_inst), .if_isTaken(if_isTaken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit          m_valid = 1'b0;
  bit          m_ce;
  logic [31:0] m_pc;
  int          m_cnt [64];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] br(int op, logic [15:0] off);
    logic [5:0] o;
    o = 6'(op);
    return {o, 10'h0, off};
  endfunction

  task automatic step();
    logic [31:0] inst;
    int          op;
    int          idx;
    bit          pred;
    logic [31:0] tgt;
    #1;
    inst = mem[m_pc[9:2]];
    op   = int'(inst[31:26]);
    idx  = int'(m_pc[7:2]);
    pred = m_ce && op >= 4 && op <= 7 && m_cnt[idx] >= 2;
    tgt  = m_pc + 32'd4 + 32'(int'($signed(inst[15:0])) * 4);
    if (m_valid) begin
      chk("rom_ce", 32'(rom_ce), 32'(m_ce));
      chk("rom_addr", rom_addr, m_pc);
      chk("if_pc", if_pc, m_ce ? m_pc : 32'h0);
      chk("if_inst", if_inst, m_ce ? inst : 32'h0);
      chk("if_isTaken", 32'(if_isTaken), 32'(pred));
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b1;
      m_ce    = 1'b0;
      m_pc    = 32'h0;
      for (int i = 0; i < 64; i++) m_cnt[i] = 1;
    end else begin
      if (m_ce) begin
        if (redirect_valid) m_pc = redirect_pc;
        else if (stall[0])  m_pc = m_pc;
        else if (pred)      m_pc = tgt;
        else                m_pc = m_pc + 32'd4;
      end
      m_ce = 1'b1;
      if (upd_valid) begin
        idx = int'(upd_pc[7:2]);
        if (upd_taken) m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
        else           m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
      end
    end
    #1;
  endtask

  task automatic go_to(logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = '0;
    redirect_valid = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4]  = br(4, 16'h0003);
    mem[16] = br(5, 16'hFFFE);

    // reset then sequential run
    step(); step();
    rst = 1'b0;
    chk("reset_ce", 32'(rom_ce), 32'h0);
    chk("reset_addr", rom_addr, 32'h0);
    step();
    chk("run0", rom_addr, 32'h0);
    step(); chk("run4", rom_addr, 32'h4);
    step(); chk("run8", rom_addr, 32'h8);
    step(); chk("runC", rom_addr, 32'hC);

    // cold branch
    step();
    chk("cold_tk", 32'(if_isTaken), 32'h0);
    step(); chk("cold_next", rom_addr, 32'h14);
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1;
    repeat (3) step();
    upd_valid = 1'b0;
    go_to(32'h10);
    chk("hot_tk", 32'(if_isTaken), 32'h1);
    step(); chk("hot_next", rom_addr, 32'h20);

    // negative offset and saturation
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
    repeat (4) step();
    upd_valid = 1'b0;
    go_to(32'h40);
    chk("neg_tk", 32'(if_isTaken), 32'h1);
    step(); chk("neg_tgt", rom_addr, 32'h3C);
    upd_valid = 1'b1; upd_taken = 1'b0;
    repeat (5) step();
    upd_valid = 1'b0;
    go_to(32'h40);
    chk("sat0_tk", 32'(if_isTaken), 32'h0);
    step(); chk("sat0_next", rom_addr, 32'h44);

    // stall hold
    rst = 1'b1; step(); rst = 1'b0;
    step(); step(); step();
    chk("stall_pc8", rom_addr, 32'h8);
    stall = 6'b000011;
    for (int i = 0; i < 3; i++) begin
      step(); chk("stall_hold", rom_addr, 32'h8);
    end
    stall = '0;
    step(); chk("stall_rel", rom_addr, 32'hC);

    // redirect beats stall, same-cycle update uses old counter
    step();
    stall = 6'b000001;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1;
    #1;
    chk("old_ctr_tk", 32'(if_isTaken), 32'h0);
    step();
    chk("redir_stall", rom_addr, 32'h100);
    stall = '0; redirect_valid = 1'b0; upd_valid = 1'b0;
    go_to(32'h10);
    chk("new_ctr_tk", 32'(if_isTaken), 32'h1);

    // wrap-around
    go_to(32'hFFFF_FFFC);
    chk("wrap_pre", rom_addr, 32'hFFFF_FFFC);
    step(); chk("wrap_post", rom_addr, 32'h0);

    // reset mid-run drops redirect and update
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1;
    step();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    chk("mid_rst_ce", 32'(rom_ce), 32'h0);
    chk("mid_rst_pc", rom_addr, 32'h0);
    rst = 1'b0; redirect_valid = 1'b0; upd_valid = 1'b0;
    step();
    go_to(32'h10);
    chk("mid_rst_bht", 32'(if_isTaken), 32'h0);

    // random traffic
    for (int i = 0; i < 256; i++) begin
      int op;
      if ($urandom_range(0, 2) == 0) begin
        mem[i] = br($urandom_range(4, 7), 16'($urandom));
      end else begin
        op = $urandom_range(0, 63);
        if (op >= 4 && op <= 7) op += 8;
        mem[i] = {6'(op), 26'($urandom)};
      end
    end
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      stall          = 6'($urandom);
      stall[0]       = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = {22'h0, 8'($urandom), 2'b00};
      upd_valid      = $urandom_range(0, 1);
      upd_pc         = {$urandom} & 32'hFFFF_FFFC;
      upd_taken      = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_pc_predictor.md
Name: if_pc_predictor

Overview:
Instruction-fetch front end that generates the fetch PC and drives the instruction ROM. It supplies if_pc, if_inst and the predicted-taken flag to the IF/ID pipeline register. A branch history table (BHT) of 2-bit saturating counters predicts conditional branches, and the next PC is steered to the predicted target. Later stages resolve each branch, update the BHT, and force a redirect on a misprediction.

Parameters:
BHT_IDX_W, 6, log2 of BHT entries (64 entries); index = pc[BHT_IDX_W+1:2]
RESET_PC, 32'h00000000, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall  in  6  pipeline stall vector from CTRL; stall[0] holds the PC
rom_ce  out  1  instruction ROM chip enable
rom_addr  out  32  instruction ROM address (= pc)
rom_data  in  32  instruction word; combinational read of rom_addr
if_pc  out  32  PC of the word currently fetched
if_inst  out  32  fetched instruction
if_isTaken  out  1  1 = this instruction is predicted taken
redirect_valid  in  1  misprediction from the resolving stage; fetch restarts
redirect_pc  in  32  correct next PC
upd_valid  in  1  a conditional branch has resolved this cycle
upd_pc  in  32  PC of the resolved branch
upd_taken  in  1  actual outcome

Behaviour:
- Reset (rst=1 at posedge): pc<=RESET_PC; ce<=0; all BHT counters <=2'b01 (weakly not-taken).
- The first cycle after reset still has ce=0. ce rises at the next edge; the first fetch occurs when ce=1.
- While ce=0: rom_addr=pc, if_pc=0, if_inst=0, if_isTaken=0, pc not advanced.
- rom_addr=pc. if_pc=pc, if_inst=rom_data when ce=1. All three are combinational from registered pc.
- Branch detect (combinational, on if_inst): opcode[31:26] in {000100 beq, 000101 bne, 000110 blez, 000111 bgtz}. No other opcode is predicted; j/jal/jr are handled downstream.
- target = pc + 4 + (sign_extend(inst[15:0]) << 2), 32-bit wrap-around arithmetic.
- if_isTaken = is_branch & bht[pc idx][1].
- Next-PC priority at each posedge with ce=1:
  1. redirect_valid: pc<=redirect_pc, even when stall[0]=1.
  2. stall[0]=1: pc holds.
  3. if_isTaken: pc<=target.
  4. Otherwise: pc<=pc+4, wrapping at 32'hFFFFFFFC -> 0.
- Misprediction latency: the redirected PC appears on rom_addr the cycle after the edge that samples redirect_valid (one-cycle bubble in IF).
- BHT update on upd_valid at posedge, index upd_pc[BHT_IDX_W+1:2]:
  - taken: counter +1, saturating at 11.
  - not-taken: counter -1, saturating at 00.
  - The update is independent of stall and redirect; it is blocked only by rst.
- Same-cycle read/update of one entry: the prediction uses the old counter value; the new value is visible from the next cycle.
- BHT aliasing between PCs that share an index is permitted; no tags are kept.
- Reset mid-operation: all state returns to reset values at that edge, and any pending redirect or update is dropped.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; predict taken iff bit1=1.

Test Plan:
- Reset then run: rst high for 2 cycles, then low; ROM filled with NOPs -> ce=0 for one cycle after reset, then rom_addr sequence 0,4,8,C; if_isTaken=0 throughout.
- Cold branch: beq at 0x10 with offset 0x0003 after reset -> if_isTaken=0 and next rom_addr=0x14. Three upd_valid taken updates for pc 0x10 -> counter 11. On the next fetch of 0x10, if_isTaken=1 and next rom_addr=0x20.
- Negative offset / saturation: bne at 0x40 with offset 0xFFFE and counter at 11. A further taken update keeps 11, and the target is 0x3C. Four not-taken updates leave the counter at 00, and a fifth keeps it at 00.
- Stall hold: stall=6'b000011 for 3 cycles at pc=0x8 -> rom_addr stays 0x8. On release, rom_addr=0xC.
- Redirect beats stall: stall[0]=1 with redirect_valid=1 and redirect_pc=0x100 -> next rom_addr=0x100. Simultaneously, upd_valid for the same index as the current pc -> the prediction this cycle uses the old counter.
- Wrap: pc=0xFFFFFFFC holding a non-branch -> next pc=0x00000000. Asserting rst mid-sequence -> pc=RESET_PC, ce=0 and BHT reset to 01.
